// File: rtl/mem_pkg.sv
// Shared types for the core-to-memory bridge: access sizes, FSM states and
// the size-to-byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } bridge_state_t;

  function automatic int size_bytes(input mem_size_t sz);
    case (sz)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Variable-latency memory bus: request/grant on the way out, rvalid/rdata
// on the way back.
interface mem_bridge_if #(
  parameter int XLEN  = 32,
  parameter int BUS_W = 32
) ();

  logic                 bus_req;
  logic                 bus_we;
  logic [XLEN-1:0]      bus_addr;
  logic [BUS_W/8-1:0]   bus_be;
  logic [BUS_W-1:0]     bus_wdata;
  logic                 bus_gnt;
  logic                 bus_rvalid;
  logic [BUS_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables and data shift, and load shift
// with sign/zero extension to the core word width.
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BUS_W = 32
) (
  input  logic [$clog2(BUS_W/8)-1:0] i_st_lane,
  input  mem_size_t                  i_st_size,
  input  logic [XLEN-1:0]            i_wdata,
  output logic [BUS_W/8-1:0]         o_be,
  output logic [BUS_W-1:0]           o_wdata,
  input  logic [$clog2(BUS_W/8)-1:0] i_ld_lane,
  input  mem_size_t                  i_ld_size,
  input  logic                       i_ld_unsigned,
  input  logic [BUS_W-1:0]           i_rdata,
  output logic [XLEN-1:0]            o_rdata
);

  localparam int BE_W = BUS_W / 8;

  int               w_st_bytes;
  int               w_ld_bytes;
  logic [BUS_W-1:0] w_sh;
  logic             w_sign;

  always_comb begin
    o_be       = '0;
    w_st_bytes = size_bytes(i_st_size);
    for (int i = 0; i < BE_W; i++) begin
      o_be[i] = (i >= int'(i_st_lane)) && (i < int'(i_st_lane) + w_st_bytes);
    end
    o_wdata = BUS_W'(i_wdata) << {i_st_lane, 3'b000};
  end

  // The sign bit is the top bit of the accessed field after shifting it to lane 0.
  always_comb begin
    o_rdata    = '0;
    w_sign     = 1'b0;
    w_ld_bytes = size_bytes(i_ld_size);
    w_sh       = i_rdata >> {i_ld_lane, 3'b000};
    for (int i = 0; i < BUS_W; i++) begin
      if (i == 8 * w_ld_bytes - 1) w_sign = w_sh[i];
    end
    for (int i = 0; i < XLEN; i++) begin
      o_rdata[i] = (i < 8 * w_ld_bytes) ? w_sh[i] : (w_sign & ~i_ld_unsigned);
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Core-to-bus memory bridge: request/grant/response FSM with alignment
// checks, response timeout and registered core/bus outputs.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BUS_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_rden,
  input  logic                core_wren,
  input  logic [XLEN-1:0]     core_addr,
  input  mem_size_t           core_size,
  input  logic                core_unsigned,
  input  logic [XLEN-1:0]     core_wdata,
  output logic                core_busy,
  output logic                core_done,
  output logic                core_fault,
  output logic [XLEN-1:0]     core_rdata,
  mem_bridge_if.master        bus
);

  localparam int BE_W   = BUS_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(BE_W - 1);

  bridge_state_t    r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             w_fault_nx;

  logic [LANE_W-1:0] r_lane;
  mem_size_t         r_size;
  logic              r_unsigned;

  logic              r_busy, r_done, r_fault;
  logic [XLEN-1:0]   r_rdata;
  logic              r_req, r_we;
  logic [XLEN-1:0]   r_addr;
  logic [BE_W-1:0]   r_be;
  logic [BUS_W-1:0]  r_wdata;

  logic [BE_W-1:0]   w_st_be;
  logic [BUS_W-1:0]  w_st_wdata;
  logic [XLEN-1:0]   w_ld_data;
  logic [2:0]        w_amask;
  logic              w_bad;
  logic              w_tmo;

  mem_align #(.XLEN(XLEN), .BUS_W(BUS_W)) u_align (
    .i_st_lane     (core_addr[LANE_W-1:0]),
    .i_st_size     (core_size),
    .i_wdata       (core_wdata),
    .o_be          (w_st_be),
    .o_wdata       (w_st_wdata),
    .i_ld_lane     (r_lane),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_rdata       (bus.bus_rdata),
    .o_rdata       (w_ld_data)
  );

  assign w_amask = 3'(size_bytes(core_size) - 1);
  assign w_bad   = (core_rden & core_wren)
                 | (|(core_addr[2:0] & w_amask))
                 | ((core_size == SZ_D) && (XLEN == 32));
  // Fault once the count would reach TIMEOUT with still no response.
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    w_cnt_nx   = r_cnt;
    w_fault_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_rden | core_wren) begin
          if (w_bad) begin
            w_next     = S_DONE;
            w_fault_nx = 1'b1;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          w_next   = S_WAIT;
          w_cnt_nx = '0;
        end
      end
      S_WAIT: begin
        if (bus.bus_rvalid) begin
          w_next = S_DONE;
        end else if (w_tmo) begin
          w_next     = S_DONE;
          w_fault_nx = 1'b1;
          w_cnt_nx   = r_cnt + 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_lane     <= '0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_fault <= w_fault_nx;
      if (r_state == S_IDLE && w_next == S_REQ) begin
        r_lane     <= core_addr[LANE_W-1:0];
        r_size     <= core_size;
        r_unsigned <= core_unsigned;
        r_req      <= 1'b1;
        r_we       <= core_wren;
        r_addr     <= core_addr & ADDR_MASK;
        r_be       <= w_st_be;
        r_wdata    <= core_wren ? w_st_wdata : '0;
      end
      if (r_state == S_REQ && bus.bus_gnt) begin
        r_req   <= 1'b0;
        r_addr  <= '0;
        r_be    <= '0;
        r_wdata <= '0;
      end
      if (r_state == S_WAIT && bus.bus_rvalid && !r_we) begin
        r_rdata <= w_ld_data;
      end
    end
  end

  assign core_busy     = r_busy;
  assign core_done     = r_done;
  assign core_fault    = r_fault;
  assign core_rdata    = r_rdata;
  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we & r_req;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge (XLEN=32, BUS_W=32, TIMEOUT=4).
module tb_mem_bridge;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_rden = 1'b0, core_wren = 1'b0, core_unsigned = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  mem_size_t   core_size = SZ_W;
  logic        core_busy, core_done, core_fault;
  logic [31:0] core_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  mem_bridge_if #(.XLEN(32), .BUS_W(32)) bus ();

  mem_bridge #(.XLEN(32), .BUS_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .core_rden     (core_rden),
    .core_wren     (core_wren),
    .core_addr     (core_addr),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_wdata    (core_wdata),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .core_fault    (core_fault),
    .core_rdata    (core_rdata),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle pulse; returns positioned in cycle N+1.
  task automatic pulse(input logic rd, input logic wr, input logic [31:0] addr,
                       input mem_size_t sz, input logic uns, input logic [31:0] wd);
    core_rden = rd; core_wren = wr; core_addr = addr;
    core_size = sz; core_unsigned = uns; core_wdata = wd;
    tick();
    core_rden = 1'b0; core_wren = 1'b0;
  endtask

  // Grant in N+1, respond in N+2, check completion in N+3.
  task automatic fast_load(input string tag, input logic [31:0] addr, input mem_size_t sz,
                           input logic uns, input logic [31:0] rdata,
                           input logic [3:0] be, input logic [31:0] exp);
    pulse(1'b1, 1'b0, addr, sz, uns, 32'h0);
    chk({tag, "_req"}, bus.bus_req, 1);
    chk({tag, "_be"}, bus.bus_be, be);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    chk({tag, "_done_n2"}, core_done, 0);
    bus.bus_rvalid = 1'b1; bus.bus_rdata = rdata;
    tick();
    bus.bus_rvalid = 1'b0;
    chk({tag, "_done"}, core_done, 1);
    chk({tag, "_fault"}, core_fault, 0);
    chk({tag, "_rdata"}, core_rdata, exp);
    tick();
  endtask

  initial begin
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    repeat (2) tick();
    chk("rst_busy", core_busy, 0);
    chk("rst_done", core_done, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_req", bus.bus_req, 0);
    rst_n = 1'b1;
    tick();

    // Aligned word load with full-latency timing checks
    pulse(1'b1, 1'b0, 32'h100, SZ_W, 1'b0, 32'h0);
    chk("wl_req", bus.bus_req, 1);
    chk("wl_we", bus.bus_we, 0);
    chk("wl_addr", bus.bus_addr, 32'h100);
    chk("wl_be", bus.bus_be, 4'hF);
    chk("wl_busy", core_busy, 1);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    chk("wl_req_drop", bus.bus_req, 0);
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hDEADBEEF;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("wl_done", core_done, 1);
    chk("wl_rdata", core_rdata, 32'hDEADBEEF);
    tick();
    chk("wl_done_pulse", core_done, 0);
    chk("wl_idle", core_busy, 0);

    // Byte store at lane 3, request held while grant is delayed
    pulse(1'b0, 1'b1, 32'h103, SZ_B, 1'b0, 32'h000000AB);
    tick();
    chk("bs_hold_req", bus.bus_req, 1);
    chk("bs_we", bus.bus_we, 1);
    chk("bs_addr", bus.bus_addr, 32'h100);
    chk("bs_be", bus.bus_be, 4'h8);
    chk("bs_wdata", bus.bus_wdata, 32'hAB000000);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    chk("bs_wdata_drop", bus.bus_wdata, 0);
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h12345678;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("bs_done", core_done, 1);
    chk("bs_rdata_kept", core_rdata, 32'hDEADBEEF);
    tick();

    fast_load("hs", 32'h102, SZ_H, 1'b0, 32'h80011234, 4'hC, 32'hFFFF8001);
    fast_load("hu", 32'h102, SZ_H, 1'b1, 32'h80011234, 4'hC, 32'h00008001);
    fast_load("bs", 32'h101, SZ_B, 1'b0, 32'h00007F00, 4'h2, 32'h0000007F);
    fast_load("bn", 32'h101, SZ_B, 1'b0, 32'h00009100, 4'h2, 32'hFFFFFF91);

    // Misaligned, double-pulse and illegal-size requests fault immediately
    pulse(1'b1, 1'b0, 32'h102, SZ_W, 1'b0, 32'h0);
    chk("mis_done", core_done, 1);
    chk("mis_fault", core_fault, 1);
    chk("mis_req", bus.bus_req, 0);
    chk("mis_rdata", core_rdata, 32'hFFFFFF91);
    tick();
    chk("mis_clear", core_done, 0);
    pulse(1'b1, 1'b1, 32'h100, SZ_W, 1'b0, 32'h0);
    chk("both_fault", {core_done, core_fault, bus.bus_req}, 3'b110);
    tick();
    pulse(1'b1, 1'b0, 32'h100, SZ_D, 1'b0, 32'h0);
    chk("dsz_fault", {core_done, core_fault, bus.bus_req}, 3'b110);
    tick();

    // Timeout: four response-less WAIT cycles, late rvalid ignored
    pulse(1'b1, 1'b0, 32'h200, SZ_W, 1'b0, 32'h0);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    repeat (3) tick();
    chk("to_not_yet", core_done, 0);
    tick();
    chk("to_done", core_done, 1);
    chk("to_fault", core_fault, 1);
    chk("to_rdata", core_rdata, 32'hFFFFFF91);
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h55555555;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("to_late", {core_done, core_busy}, 2'b00);
    chk("to_late_rdata", core_rdata, 32'hFFFFFF91);

    // rvalid on the final WAIT cycle beats the timeout
    pulse(1'b1, 1'b0, 32'h204, SZ_W, 1'b0, 32'h0);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    repeat (3) tick();
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("race_done", core_done, 1);
    chk("race_fault", core_fault, 0);
    chk("race_rdata", core_rdata, 32'hCAFEF00D);
    tick();

    // Pulse while busy is ignored
    pulse(1'b1, 1'b0, 32'h100, SZ_W, 1'b0, 32'h0);
    pulse(1'b0, 1'b1, 32'h104, SZ_W, 1'b0, 32'h11111111);
    chk("busy_we", bus.bus_we, 0);
    chk("busy_addr", bus.bus_addr, 32'h100);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h0BADF00D;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("busy_done", core_rdata, 32'h0BADF00D);
    repeat (2) tick();
    chk("busy_no_second", {bus.bus_req, core_busy}, 2'b00);

    // Reset while waiting; a following response must not complete
    pulse(1'b1, 1'b0, 32'h300, SZ_W, 1'b0, 32'h0);
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("wrst_busy", core_busy, 0);
    chk("wrst_rdata", core_rdata, 0);
    tick();
    rst_n = 1'b1;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h77777777;
    tick();
    bus.bus_rvalid = 1'b0;
    chk("wrst_no_done", core_done, 0);
    chk("wrst_rdata_after", core_rdata, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
